// File: rtl/sram_access_arbiter.sv
// Two-way arbiter (audio datapath / host) for the single quad-SPI audio SRAM.
// Optional WAIT-state timeout compiled in with `define SRAM_ARB_TIMEOUT_EN.
module sram_access_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int MAX_AUD_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              aud_req,
    input  logic              aud_we,
    input  logic [ADDR_W-1:0] aud_addr,
    input  logic [7:0]        aud_wdata,
    output logic              aud_ack,
    output logic [7:0]        aud_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,

    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_done,
    input  logic [7:0]        mem_rdata,

    output logic              grant_host,
    output logic              arb_busy,
    input  logic              err_clr,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] RUN_MAX  = 4'(MAX_AUD_RUN);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic                owner_host_reg, owner_host_next;
    logic [3:0]          aud_run_cnt_reg, aud_run_cnt_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [7:0]          mem_wdata_reg, mem_wdata_next;
    logic                mem_start_reg, mem_start_next;
    logic                arb_busy_reg, arb_busy_next;
    logic                aud_ack_reg, aud_ack_next;
    logic                host_ack_reg, host_ack_next;
    logic [7:0]          aud_rdata_reg, aud_rdata_next;
    logic [7:0]          host_rdata_reg, host_rdata_next;
    logic                pick_host;
    logic                cap_en;
    logic [7:0]          cap_data;

`ifdef SRAM_ARB_TIMEOUT_EN
    logic [7:0]          tmo_cnt_reg, tmo_cnt_next;
    logic                timeout_err_reg, timeout_err_next;
    logic                tmo_set;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            owner_host_reg  <= 1'b0;
            aud_run_cnt_reg <= 4'd0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= 8'h00;
            mem_start_reg   <= 1'b0;
            arb_busy_reg    <= 1'b0;
            aud_ack_reg     <= 1'b0;
            host_ack_reg    <= 1'b0;
            aud_rdata_reg   <= 8'h00;
            host_rdata_reg  <= 8'h00;
        end else begin
            state_reg       <= state_next;
            owner_host_reg  <= owner_host_next;
            aud_run_cnt_reg <= aud_run_cnt_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            mem_start_reg   <= mem_start_next;
            arb_busy_reg    <= arb_busy_next;
            aud_ack_reg     <= aud_ack_next;
            host_ack_reg    <= host_ack_next;
            aud_rdata_reg   <= aud_rdata_next;
            host_rdata_reg  <= host_rdata_next;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg     <= 8'd0;
            timeout_err_reg <= 1'b0;
        end else begin
            tmo_cnt_reg     <= tmo_cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end
`endif

    always_comb begin
        state_next       = state_reg;
        owner_host_next  = owner_host_reg;
        aud_run_cnt_next = aud_run_cnt_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        pick_host        = 1'b0;
        cap_en           = 1'b0;
        cap_data         = mem_rdata;
`ifdef SRAM_ARB_TIMEOUT_EN
        tmo_cnt_next     = 8'd0;
        tmo_set          = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                // A host that is not waiting restarts the starvation window.
                if (!host_req) begin
                    aud_run_cnt_next = 4'd0;
                end
                if (aud_req || host_req) begin
                    pick_host       = host_req && (!aud_req || (aud_run_cnt_reg >= RUN_MAX));
                    owner_host_next = pick_host;
                    state_next      = ST_ISSUE;
                    if (pick_host) begin
                        mem_we_next      = host_we;
                        mem_addr_next    = host_addr;
                        mem_wdata_next   = host_wdata;
                        aud_run_cnt_next = 4'd0;
                    end else begin
                        mem_we_next    = aud_we;
                        mem_addr_next  = aud_addr;
                        mem_wdata_next = aud_wdata;
                        if (host_req) begin
                            aud_run_cnt_next = (aud_run_cnt_reg >= RUN_MAX) ?
                                               RUN_MAX : aud_run_cnt_reg + 4'd1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done) begin
                    cap_en     = 1'b1;
                    state_next = ST_RESP;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_LAST) begin
                    // Give the owner a recognisable dummy byte rather than stalling it.
                    cap_en     = 1'b1;
                    cap_data   = 8'hFF;
                    tmo_set    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        aud_rdata_next  = (cap_en && !owner_host_reg) ? cap_data : aud_rdata_reg;
        host_rdata_next = (cap_en &&  owner_host_reg) ? cap_data : host_rdata_reg;

        // Outputs are registered from the next state so they line up with it.
        mem_start_next = (state_next == ST_ISSUE);
        arb_busy_next  = (state_next != ST_IDLE);
        aud_ack_next   = (state_next == ST_RESP) && !owner_host_next;
        host_ack_next  = (state_next == ST_RESP) &&  owner_host_next;

`ifdef SRAM_ARB_TIMEOUT_EN
        timeout_err_next = (timeout_err_reg || tmo_set) && !err_clr;
`endif
    end

    assign aud_ack    = aud_ack_reg;
    assign aud_rdata  = aud_rdata_reg;
    assign host_ack   = host_ack_reg;
    assign host_rdata = host_rdata_reg;
    assign mem_start  = mem_start_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign grant_host = owner_host_reg;
    assign arb_busy   = arb_busy_reg;

`ifdef SRAM_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_reg;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr ^ (^TMO_LAST);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Arbitrates the single quad-SPI audio SRAM between two requesters: the audio datapath (delay-line/buffer traffic from the audio processing chain) and the host (SPI register-file accesses from the Raspberry Pi). It grants one byte transaction at a time to the downstream SRAM serial controller and returns read data and an acknowledge to the owner. Audio has priority, with a bounded-starvation rule for the host. It sits between the audio processing block, the SPI register interface and the SRAM serial controller, all in the `clk` domain.

## Interface
Parameters:
- `ADDR_W`, 17, SRAM byte address width (128 KB device).
- `MAX_AUD_RUN`, 4, maximum consecutive audio grants while host waits; legal range 1–15.
- `TIMEOUT`, 255, WAIT-state cycle limit; used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `aud_req`  in  1  audio request; level, held until `aud_ack`.
- `aud_we`  in  1  audio write enable (1 = write).
- `aud_addr`  in  ADDR_W  audio byte address.
- `aud_wdata`  in  8  audio write data.
- `aud_ack`  out  1  one-cycle completion pulse.
- `aud_rdata`  out  8  read data; valid in the `aud_ack` cycle and held until the next audio ack.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`: same as the audio ports, for the host.
- `mem_start`  out  1  one-cycle transaction start.
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/8  registered; stable from `mem_start` until `mem_done`.
- `mem_done`  in  1  controller completion pulse.
- `mem_rdata`  in  8  sampled in the `mem_done` cycle.
- `grant_host`  out  1  1 = current or last owner is host.
- `arb_busy`  out  1  1 in every state except IDLE.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**: sample the requests.
  - Only one request asserted: grant it.
  - Both asserted: grant host if `aud_run_cnt >= MAX_AUD_RUN`, otherwise audio.
  - On a grant: latch the owner's we/addr/wdata into the `mem_*` registers, set `grant_host`, go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE**: `mem_start` = 1 for exactly one cycle, then WAIT. `mem_done` is ignored in ISSUE.
- **WAIT**: on `mem_done`, capture `mem_rdata` into the owner's rdata register (for writes too) and go to RESP.
- **RESP**: owner's ack = 1 for one cycle, then IDLE.
- Requester rule: sample ack and drop req (or present new fields) at the next edge. IDLE follows RESP, so a request is never granted twice.
- `aud_run_cnt` (4 bits):
  - Audio grant with `host_req` = 1: increment, saturating at `MAX_AUD_RUN`.
  - Host grant, or `host_req` = 0 in IDLE: clear to 0.
- Write fields arriving mid-transaction are ignored; only the IDLE-cycle values are used.
- Reset values: all outputs 0, rdata registers 8'h00, state IDLE, counter 0, `timeout_err` 0.
- Reset mid-transaction: immediate return to IDLE, no ack issued. The SRAM controller shares `reset`, so no cleanup handshake exists.

## Timing
- Request visible in IDLE in cycle 0 → `mem_start` high in cycle 1 → WAIT from cycle 2.
- `mem_done` in cycle k (k ≥ 2) → ack and rdata in cycle k+1 → IDLE in cycle k+2.
- Minimum transaction is 4 cycles (IDLE, ISSUE, WAIT, RESP). Back-to-back grants are therefore at least 4 cycles apart.
- All outputs are registered; no combinational path from any input to any output.
- `arb_busy` is 1 from the cycle after the grant through the RESP cycle.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT.
  - If `TIMEOUT` cycles pass without `mem_done`, go to RESP with owner rdata = 8'hFF and set `timeout_err`.
  - `timeout_err` stays set until `err_clr` = 1 (clear wins over a simultaneous set).
  - A `mem_done` arriving after the timeout is ignored, even if it arrives in IDLE.
- Not defined: WAIT holds indefinitely, `timeout_err` is tied 0, `err_clr` is unused.

## Test plan
- Host read, controller returns 8'h5A three cycles after `mem_start` → `host_ack` in the cycle after `mem_done`, `host_rdata` = 8'h5A, `grant_host` = 1, exactly one `mem_start`.
- Audio write addr 17'h1F000, data 8'hC3 → `mem_we` = 1, `mem_addr` = 17'h1F000, `mem_wdata` = 8'hC3 stable from start to done, `aud_ack` pulses once.
- `aud_req` and `host_req` held continuously with `MAX_AUD_RUN` = 4 → grant order A,A,A,A,H,A,A,A,A,H.
- Both requests rise in the same IDLE cycle, counter 0 → audio granted first, host second.
- Assert `reset` during WAIT → all outputs 0 within the same cycle (async). After release, a pending `host_req` is granted fresh with no stale ack.
- With `SRAM_ARB_TIMEOUT_EN` and `mem_done` never asserted → ack at WAIT entry + 255 cycles with rdata 8'hFF, `timeout_err` = 1; `err_clr` pulse → `timeout_err` = 0.
